// File: rtl/candy_avb_test_qsys_i2c_sda_in_if.sv
`default_nettype none
// ============================================================================
// Module   : candy_avb_test_qsys_i2c_sda_in_if
// Brief    : Avalon-MM slave bus bundle (address/strobes/data/irq) for the
//            I2C line-input peripheral.
// Revision : 1.0 - initial release
// ============================================================================
interface candy_avb_test_qsys_i2c_sda_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface
`default_nettype wire

// File: rtl/candy_avb_test_qsys_i2c_sda_in.sv
`default_nettype none
// ============================================================================
// Module   : candy_avb_test_qsys_i2c_sda_in
// Brief    : Synchronised, optionally glitch-filtered I2C line input with
//            edge capture, maskable level irq and Avalon-MM register access.
//            Define I2C_SDA_IN_GLITCH_FILTER_EN to build in the glitch filter.
// Revision : 1.0 - initial release
// ============================================================================
module candy_avb_test_qsys_i2c_sda_in #(
  parameter int FILTER_CYCLES = 4
) (
  input  wire logic clk,
  input  wire logic reset_n,
  input  wire logic in_port,
  candy_avb_test_qsys_i2c_sda_in_if.slave bus
);

  localparam logic [1:0] C_ADDR_DATA = 2'd0;
  localparam logic [1:0] C_ADDR_RSVD = 2'd1;
  localparam logic [1:0] C_ADDR_MASK = 2'd2;
  localparam logic [1:0] C_ADDR_EDGE = 2'd3;

  logic        r_sync_meta;
  logic        r_sync_q;
  logic        r_filt_q;
  logic        r_prev_q;
  logic        r_irq_mask;
  logic        r_edge_cap;
  logic [31:0] r_readdata;

  logic        w_wr;
  logic        w_edge;
  logic        w_clear;
  logic [30:0] w_unused_wdata;

  assign w_wr           = bus.chipselect && !bus.write_n;
  assign w_edge         = r_filt_q ^ r_prev_q;
  assign w_clear        = w_wr && (bus.address == C_ADDR_EDGE) && bus.writedata[0];
  assign w_unused_wdata = bus.writedata[31:1];

  // Idle-high reset so releasing reset on an idle bus produces no edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_meta <= 1'b1;
      r_sync_q    <= 1'b1;
      r_prev_q    <= 1'b1;
    end else begin
      r_sync_meta <= in_port;
      r_sync_q    <= r_sync_meta;
      r_prev_q    <= r_filt_q;
    end
  end

`ifdef I2C_SDA_IN_GLITCH_FILTER_EN
  localparam logic [7:0] C_CNT_LAST = 8'(FILTER_CYCLES - 1);

  logic [7:0] r_cnt;

  // r_cnt holds the number of consecutive cycles the line already disagreed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= 8'd0;
      r_filt_q <= 1'b1;
    end else if (r_sync_q == r_filt_q) begin
      r_cnt    <= 8'd0;
    end else if (r_cnt >= C_CNT_LAST) begin
      r_cnt    <= 8'd0;
      r_filt_q <= r_sync_q;
    end else if (r_cnt != 8'hFF) begin
      r_cnt    <= r_cnt + 8'd1;
    end
  end
`else
  logic [7:0] w_unused_filter;

  assign w_unused_filter = 8'(FILTER_CYCLES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_filt_q <= 1'b1;
    end else begin
      r_filt_q <= r_sync_q;
    end
  end
`endif

  // A fresh edge outranks a simultaneous W1C so no event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_edge_cap <= 1'b0;
      r_irq_mask <= 1'b0;
    end else begin
      if (w_edge) begin
        r_edge_cap <= 1'b1;
      end else if (w_clear) begin
        r_edge_cap <= 1'b0;
      end
      if (w_wr && (bus.address == C_ADDR_MASK)) begin
        r_irq_mask <= bus.writedata[0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
    end else begin
      case (bus.address)
        C_ADDR_DATA: r_readdata <= {31'd0, r_filt_q};
        C_ADDR_RSVD: r_readdata <= 32'd0;
        C_ADDR_MASK: r_readdata <= {31'd0, r_irq_mask};
        C_ADDR_EDGE: r_readdata <= {31'd0, r_edge_cap};
        default:     r_readdata <= 32'd0;
      endcase
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = r_edge_cap & r_irq_mask;

endmodule
`default_nettype wire

// File: tb/tb_candy_avb_test_qsys_i2c_sda_in.sv
`default_nettype none
// ============================================================================
// Module   : tb_candy_avb_test_qsys_i2c_sda_in
// Brief    : Directed plus randomised bench against a run-length line model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_candy_avb_test_qsys_i2c_sda_in;

  localparam int FC = 4;
`ifdef I2C_SDA_IN_GLITCH_FILTER_EN
  localparam int LAT = 2 + FC;
`else
  localparam int LAT = 3;
`endif

  logic clk;
  logic reset_n;
  logic in_port;
  int   vectors;
  int   miscompares;

  candy_avb_test_qsys_i2c_sda_in_if bus ();

  candy_avb_test_qsys_i2c_sda_in #(.FILTER_CYCLES(FC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: line seen two clocks late; level follows once a run of FC equal samples differs.
  logic        m_s1, m_sync, m_filt, m_prev, m_cap, m_mask;
  int          m_run;
  logic [31:0] m_rd;
  logic        m_wr;
  assign m_wr = bus.chipselect && !bus.write_n;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_s1 <= 1'b1; m_sync <= 1'b1; m_run <= 0;
      m_filt <= 1'b1; m_prev <= 1'b1; m_cap <= 1'b0; m_mask <= 1'b0; m_rd <= 32'd0;
    end else begin
      m_s1   <= in_port;
      m_sync <= m_s1;
      m_run  <= (m_s1 == m_sync) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
`ifdef I2C_SDA_IN_GLITCH_FILTER_EN
      if (m_sync != m_filt && m_run >= FC) m_filt <= m_sync;
`else
      m_filt <= m_sync;
`endif
      m_prev <= m_filt;
      if (m_filt != m_prev) m_cap <= 1'b1;
      else if (m_wr && bus.address == 2'd3 && bus.writedata[0]) m_cap <= 1'b0;
      if (m_wr && bus.address == 2'd2) m_mask <= bus.writedata[0];
      m_rd <= (bus.address == 2'd0) ? {31'd0, m_filt} :
              (bus.address == 2'd2) ? {31'd0, m_mask} :
              (bus.address == 2'd3) ? {31'd0, m_cap}  : 32'd0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk("readdata", bus.readdata, m_rd);
      chk("irq", {31'd0, bus.irq}, {31'd0, m_cap & m_mask});
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    cyc(1);
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd0; bus.writedata = 32'd0;
  endtask

  task automatic rd_expect(input string tag, input logic [1:0] a, input logic [31:0] exp);
    bus.address = a;
    cyc(1);
    chk(tag, bus.readdata, exp);
    bus.address = 2'd0;
  endtask

  task automatic measure_fall(input string tag);
    int k;
    k = 0;
    bus.address = 2'd0;
    in_port = 1'b0;
    do begin
      cyc(1);
      k++;
    end while (bus.readdata[0] !== 1'b0 && k < 20);
    chk(tag, k, LAT + 1);
  endtask

  initial begin
    int runleft;
    int r;
    vectors = 0; miscompares = 0;
    reset_n = 1'b0; in_port = 1'b1;
    bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
    cyc(3);
    chk("reset_rd", bus.readdata, 32'd0);
    chk("reset_irq", {31'd0, bus.irq}, 32'd0);
    reset_n = 1'b1;
    cyc(2);
    chk("idle_data", bus.readdata, 32'd1);
    rd_expect("idle_edge", 2'd3, 32'd0);
    chk("idle_irq", {31'd0, bus.irq}, 32'd0);

    // Masked step: exact latency, capture and irq.
    wr(2'd2, 32'd1);
    wr(2'd0, 32'd0);
    rd_expect("data_ro", 2'd0, 32'd1);
    measure_fall("fall_latency");
    rd_expect("edge_set", 2'd3, 32'd1);
    chk("irq_set", {31'd0, bus.irq}, 32'd1);
    wr(2'd1, 32'hFFFF_FFFF);
    rd_expect("rsvd_zero", 2'd1, 32'd0);
    wr(2'd3, 32'd0);
    chk("w0_noclear", {31'd0, bus.irq}, 32'd1);
    wr(2'd3, 32'd1);
    chk("w1c_irq", {31'd0, bus.irq}, 32'd0);

    // Short low glitch on an idle line.
    in_port = 1'b1;
    cyc(12);
    wr(2'd3, 32'd1);
    in_port = 1'b0;
    cyc(3);
    in_port = 1'b1;
    cyc(12);
`ifdef I2C_SDA_IN_GLITCH_FILTER_EN
    rd_expect("glitch_edge", 2'd3, 32'd0);
    rd_expect("glitch_data", 2'd0, 32'd1);
`endif
    wr(2'd3, 32'd1);
    cyc(2);

    // Clear write lands on the very cycle the edge is seen.
    in_port = 1'b0;
    cyc(LAT);
    wr(2'd3, 32'd1);
    rd_expect("set_wins", 2'd3, 32'd1);

    // Reset in the middle of a low pulse.
    in_port = 1'b1;
    cyc(12);
    wr(2'd3, 32'd1);
    in_port = 1'b0;
    cyc(2);
    reset_n = 1'b0;
    cyc(2);
    chk("midrst_rd", bus.readdata, 32'd0);
    reset_n = 1'b1; in_port = 1'b1;
    cyc(10);
    chk("postrst_data", bus.readdata, 32'd1);
    rd_expect("postrst_edge", 2'd3, 32'd0);
    rd_expect("postrst_mask", 2'd2, 32'd0);
    measure_fall("restart_latency");

    // Randomised line activity with random bus traffic.
    in_port = 1'b1;
    cyc(12);
    runleft = 0;
    for (int i = 0; i < 400; i++) begin
      if (runleft == 0) begin
        in_port = 1'($urandom_range(0, 1));
        runleft = $urandom_range(1, 8);
      end
      runleft--;
      r = $urandom_range(0, 9);
      bus.chipselect = (r < 3);
      bus.write_n    = !(r < 2);
      bus.address    = 2'($urandom_range(0, 3));
      bus.writedata  = $urandom;
      cyc(1);
    end
    bus.chipselect = 1'b0; bus.write_n = 1'b1;
    cyc(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
